// File: rtl/ram_sdp_clr_if.sv
// Port bundle for ram_sdp_clr: one write port, one read port, clear request and status.
// Handshake: wr_en/rd_en/clr are single-cycle strobes accepted only while busy is low;
// a strobe presented while busy is high is dropped. rd_valid pulses once per accepted read.
interface ram_sdp_clr_if #(
  parameter int AW = 5,
  parameter int DW = 8
) ();
  logic          clr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;

  modport master (
    output clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/ram_sdp_clr.sv
// Simple-dual-port RAM with registered write-first read and a hardware clear sequencer.
// Define RAM_SDP_OUTREG_EN to add a second output register (read latency 2).
module ram_sdp_clr #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  ram_sdp_clr_if.slave  bus,
  output logic          dbg_state_o
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;

  logic [DW-1:0] mem [DEPTH];

  logic          clearing;
  logic          acc_ok;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          rd_fire;
  logic          rd_fwd;
  logic [DW-1:0] rd_word;

  // A clr request takes priority over any access strobed in the same cycle.
  always_comb begin
    clearing  = (state_q == ST_CLEAR);
    acc_ok    = (state_q == ST_IDLE) && !bus.clr;
    cnt_d     = cnt_q + 1'b1;
    mem_we    = !rst && (clearing || (acc_ok && bus.wr_en));
    mem_waddr = clearing ? cnt_q : bus.wr_addr;
    mem_wdata = clearing ? '0 : bus.wr_data;
    rd_fire   = acc_ok && bus.rd_en;
    rd_fwd    = rd_fire && bus.wr_en && (bus.wr_addr == bus.rd_addr);
    rd_word   = rd_fwd ? bus.wr_data : mem[bus.rd_addr];
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          rd_valid_q <= 1'b0;
          // Counter stops on the last word; it is reloaded on the next clear.
          if (cnt_q == '1) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          if (bus.clr) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
          end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
              rd_data_q <= rd_word;
            end
          end
        end
      endcase
    end
  end

`ifdef RAM_SDP_OUTREG_EN
  logic [DW-1:0] rd_data2_q;
  logic          rd_valid2_q;

  // Runs independently of the FSM so a read issued just before a clear still drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data2_q  <= '0;
      rd_valid2_q <= 1'b0;
    end else begin
      rd_valid2_q <= rd_valid_q;
      if (rd_valid_q) begin
        rd_data2_q <= rd_data_q;
      end
    end
  end

  assign bus.rd_data  = rd_data2_q;
  assign bus.rd_valid = rd_valid2_q;
`else
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.busy    = (state_q == ST_CLEAR);
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_ram_sdp_clr.sv
// Bench for ram_sdp_clr: directed stimulus, expected reads queued and checked by a monitor.
module tb_ram_sdp_clr;
  localparam int AW = 5;
  localparam int DW = 8;
`ifdef RAM_SDP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [DW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  ram_sdp_clr_if #(.AW(AW), .DW(DW)) bus ();

  ram_sdp_clr #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic c, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
    bus.clr     = c;
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.rd_addr = ra;
  endtask

  task automatic step(input logic c, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                      input logic push, input logic [DW-1:0] ed);
    drive(c, we, wa, wd, re, ra);
    if (push) begin
      exp_q.push_back(ed);
      exp_cyc_q.push_back(cyc + LAT);
    end
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b0, 1'b1, a, d, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] ed);
    step(1'b0, 1'b0, '0, '0, 1'b1, a, 1'b1, ed);
  endtask

  task automatic pulse_clr();
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  // Counts post-edge samples with busy high; optionally injects traffic that must be dropped.
  task automatic count_busy(input logic traffic);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      if (traffic && n == 3) drive(1'b0, 1'b1, 5'd10, 8'd55, 1'b1, 5'd10);
      else                   drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
      if (traffic) check("rd_valid_during_busy", int'(bus.rd_valid), 0);
      @(posedge clk);
      #1;
      n++;
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    check("busy_cycles", n, 32);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [DW-1:0] ed;
    int            ec;
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_rd_valid: got no rd_valid by cycle %0d required one at cycle %0d",
               cyc, exp_cyc_q[0]);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid: got rd_valid=1 data=%0d at cycle %0d required 0",
                 bus.rd_data, cyc);
      end else begin
        ed = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("rd_data", int'(bus.rd_data), int'(ed));
        check("rd_latency_cycle", cyc, ec);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_data", int'(bus.rd_data), 0);
    check("reset_rd_valid", int'(bus.rd_valid), 0);
    check("reset_busy", int'(bus.busy), 1);
    rst = 1'b0;
    count_busy(1'b0);

    rd(5'd0, 8'd0);
    rd(5'd17, 8'd0);
    rd(5'd31, 8'd0);
    idle(3);

    wr(5'd24, 8'd45);
    rd(5'd24, 8'd45);
    idle(3);

    // Same-address forwarding, then independent read/write.
    step(1'b0, 1'b1, 5'd4, 8'd124, 1'b1, 5'd4, 1'b1, 8'd124);
    step(1'b0, 1'b1, 5'd14, 8'd7, 1'b1, 5'd24, 1'b1, 8'd45);
    rd(5'd14, 8'd7);
    rd(5'd4, 8'd124);
    idle(3);

    wr(5'd10, 8'd99);
    rd(5'd10, 8'd99);
    idle(3);
    pulse_clr();
    count_busy(1'b1);
    rd(5'd10, 8'd0);
    rd(5'd24, 8'd0);
    idle(3);

    // Fill, start a clear, then reset part-way through it.
    for (int i = 0; i < 32; i++) wr(AW'(i), DW'(i + 1));
    rd(5'd5, 8'd6);
    idle(3);
    pulse_clr();
    idle(12);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midclear_rst_rd_data", int'(bus.rd_data), 0);
    check("midclear_rst_busy", int'(bus.busy), 1);
    rst = 1'b0;
    count_busy(1'b0);
    for (int i = 0; i < 32; i++) rd(AW'(i), 8'd0);
    idle(4);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_sdp_clr.md
# ram_sdp_clr

Parametrised synchronous simple-dual-port RAM: one write port and one read port, with a registered read path, write-first same-address forwarding and a hardware clear sequencer that zeroes every word after reset or on command. It is the clocked, generalised successor to the team's fixed 32x8 asynchronous dual-address RAM. It serves as the general storage primitive for buffers and lookup tables in the design.

## Interface
- AW, 5, address width in bits
- DW, 8, data width in bits
- DEPTH, 1<<AW, number of words; fixed at 2^AW, not independently overridable

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- clr  input  1  request a full-memory clear; sampled only in IDLE
- wr_en  input  1  write strobe
- wr_addr  input  AW  write address
- wr_data  input  DW  write data
- rd_en  input  1  read strobe
- rd_addr  input  AW  read address
- rd_data  output  DW  read data, registered
- rd_valid  output  1  one-cycle pulse marking new rd_data
- busy  output  1  high while the clear sequence runs

## Operation
- FSM with two states, IDLE and CLEAR. The state register drives busy directly: busy = (state == CLEAR).
- Reset, on a clk edge with rst=1:
  - state <= CLEAR, clear counter <= 0
  - rd_data <= 0, rd_valid <= 0
- CLEAR:
  - Each cycle writes 0 to mem[cnt] and increments cnt.
  - When cnt == DEPTH-1, state <= IDLE after that cycle's write.
  - wr_en, rd_en and clr are ignored. rd_valid stays 0 and rd_data holds its value.
- IDLE:
  - clr=1 enters CLEAR with cnt <= 0. wr_en and rd_en in the same cycle are ignored.
  - wr_en=1 writes mem[wr_addr] <= wr_data.
  - rd_en=1 loads rd_data with mem[rd_addr] and pulses rd_valid for one cycle.
  - Simultaneous read and write to the same address is write-first: rd_data <= wr_data.
  - Simultaneous read and write to different addresses proceed independently.
  - rd_en=0 sets rd_valid <= 0 and rd_data holds its last value.
- A mid-operation rst, in either state, restarts CLEAR from address 0. Any partial clear is discarded and restarted.
- Addresses are always in range because DEPTH = 2^AW, so there is no wrap-around check. The clear counter is AW bits wide and terminates on DEPTH-1; it never wraps.

## Timing
- Read latency is 1 cycle: rd_en sampled at edge N gives rd_data and rd_valid valid after edge N.
- Write latency is 1 cycle. A read issued the cycle after a write returns the new data.
- Clear duration is exactly DEPTH cycles. busy is high for the DEPTH cycles after the first edge where rst=0, or after the clr-sampling edge.
- The first accepted access is at edge DEPTH+1 after rst deasserts. For AW=5 that is edge 33.
- rd_valid is never high while busy is high.
- Outputs after reset: rd_data=0, rd_valid=0, busy=1.

## Configuration
- RAM_SDP_OUTREG_EN
  - Defined: adds a second output register stage. Read latency becomes 2 cycles, with rd_valid delayed to match.
    - Forwarding is still evaluated at the request cycle.
    - The stage resets to 0.
    - A read in progress when CLEAR starts still completes on the pipeline, carrying the value captured before the clear.
  - Undefined: single output register and 1-cycle latency, as described above.

## Test plan
All scenarios use AW=5, DW=8.
- Reset, then count busy cycles. Required: busy high exactly 32 cycles. Then a read of addresses 0, 17 and 31 returns 0 with rd_valid pulsing once per read.
- IDLE, write 45 @24, then next cycle read 24. Required: rd_data=45, rd_valid=1, one cycle after the read request.
- Same cycle, wr_addr=4, wr_data=124, rd_addr=4, rd_en=1. Required: rd_data=124 next cycle (forwarding). Same cycle, write 7 @14 and read 24. Required: rd_data=45.
- Write 99 @10, then pulse clr. Required: busy for 32 cycles. During busy, write 55 @10 and read 10; both are ignored and rd_valid stays 0. After busy falls, read 10 returns 0.
- Assert rst at cnt=12 of a clear. Required: busy stays high for a further full 32 cycles after rst drops, and all words read 0.
- With RAM_SDP_OUTREG_EN defined, repeat the write-45-then-read-24 scenario. Required: rd_data=45 and rd_valid=1 two cycles after the read request, and rd_valid=0 one cycle after.
